// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants, baud divider helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package uart_pkg;

    // Ticks per bit period, and the tick at the centre of a bit.
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4,
        RX_BREAK  = 3'd5
    } uart_rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clk_freq_hz, input int baud);
        int den;
        den = baud * UART_OVERSAMPLE;
        return (clk_freq_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO: circular buffer with registered head byte and full-drop overrun pulse.
// Latency: a push shows on head_vld two clocks after push_vld is raised (write, then head register).
// Backpressure: pop on head_vld && pop_rdy; a push while full is dropped unless a pop happens that cycle.
//
// Ports: clk/rst_n (async active-low), push_vld/push_dat (write side, no ready: drop on full),
//        head_dat/head_vld/pop_rdy (read side valid/ready), overrun (one-cycle drop pulse).
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] head_dat,
    output logic             head_vld,
    input  logic             pop_rdy,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      rptr_nxt;
    logic             full;
    logic             pop;
    logic             push_ok;

    // head_vld implies the buffer is non-empty, so a pop never underflows.
    assign pop      = head_vld && pop_rdy;
    assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok  = push_vld && (!full || pop);
    assign rptr_nxt = pop ? rptr + 1'b1 : rptr;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[AW-1:0]] <= push_dat;
        end
    end

    // The head register looks ahead through this cycle's pop so it never shows a
    // stale byte after a handshake; a push only becomes visible one clock after
    // it lands in the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            head_vld <= 1'b0;
            head_dat <= '0;
            overrun  <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            rptr     <= rptr_nxt;
            head_vld <= (wptr != rptr_nxt);
            if (wptr != rptr_nxt) begin
                head_dat <= mem[rptr_nxt[AW-1:0]];
            end
            overrun  <= push_vld && full && !pop;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes rx, recovers 8N1 frames (optional even parity) at 16x oversampling, queues good bytes.
// Latency: byte valid 2 clocks after the tick-9 stop-bit sample, plus 2 clocks of input synchronizer.
// Backpressure: valid_o/ready_i pop from the FIFO; bytes arriving while it is full are dropped with overrun_o.
//
// Ports: clk, reset_pin (async active-low), rx (async serial input, idle high),
//        data_o/valid_o/ready_i (FIFO head handshake), frame_err_o, overrun_o, parity_err_o (one-cycle pulses).
// Build option: define UART_RX_PARITY_EN to add the even-parity bit and the parity_err_o port.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       reset_pin,
    input  logic       rx,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err_o
`endif
);
    localparam int              DIV      = uart_div(CLK_FREQ_HZ, BAUD);
    localparam int              DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);
    localparam logic [3:0]      S_V0     = 4'(UART_MID_SAMPLE - 1);
    localparam logic [3:0]      S_V1     = 4'(UART_MID_SAMPLE);
    localparam logic [3:0]      S_V2     = 4'(UART_MID_SAMPLE + 1);

    logic           rx_m;
    logic           rx_s;
    logic           rx_prev;
    logic [DW-1:0]  div_cnt;
    logic [3:0]     scnt;
    logic           tick;
    uart_rx_state_t state;
    logic [1:0]     votes;
    logic           maj;
    logic           sample_pt;
    logic           start_edge;
    logic [7:0]     shreg;
    logic [2:0]     bit_idx;
    logic           push_vld;
    logic           frame_err_q;
`ifdef UART_RX_PARITY_EN
    logic           par_bad;
    logic           parity_err_q;
`endif

    // Two-flop synchronizer; rx_prev only serves start-edge detection.
    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign tick       = (div_cnt == DIV_LAST);
    assign start_edge = (state == RX_IDLE) && rx_prev && !rx_s;
    // Votes hold ticks 7 and 8; tick 9 is the live sample at the decision point.
    assign maj        = (votes[0] & votes[1]) | (rx_s & (votes[0] | votes[1]));
    assign sample_pt  = tick && (scnt == S_V2);

    always_ff @(posedge clk or negedge reset_pin) begin
        if (!reset_pin) begin
            div_cnt     <= '0;
            scnt        <= '0;
            state       <= RX_IDLE;
            votes       <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            push_vld    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            push_vld    <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // Realign the bit grid to the start edge; scnt wraps every 16 ticks.
            if (start_edge) begin
                div_cnt <= '0;
                scnt    <= '0;
            end else begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) begin
                    scnt <= scnt + 1'b1;
                end
            end
            if (tick && scnt == S_V0) votes[0] <= rx_s;
            if (tick && scnt == S_V1) votes[1] <= rx_s;

            // Each state decides at tick 9 and moves on; the next state's
            // decision therefore falls at tick 9 of the following bit.
            case (state)
                RX_IDLE: begin
                    if (start_edge) state <= RX_START;
                end
                RX_START: begin
                    if (sample_pt) begin
                        if (!maj) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            par_bad <= 1'b0;
`endif
                        end else begin
                            state <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (sample_pt) begin
                        shreg   <= {maj, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (sample_pt) begin
                        // Even parity: data ones plus parity bit must be even.
                        if (maj != ^shreg) begin
                            par_bad      <= 1'b1;
                            parity_err_q <= 1'b1;
                        end
                        state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (sample_pt) begin
                        if (maj) begin
`ifdef UART_RX_PARITY_EN
                            push_vld <= !par_bad;
`else
                            push_vld <= 1'b1;
`endif
                            state    <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    assign frame_err_o = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = parity_err_q;
`endif

    uart_rx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (reset_pin),
        .push_vld (push_vld),
        .push_dat (shreg),
        .head_dat (data_o),
        .head_vld (valid_o),
        .pop_rdy  (ready_i),
        .overrun  (overrun_o)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus randomized frames checked against a byte-level line model.
// The line rate is raised so that one bit is 128 clocks, keeping the run short; proportions match the default rate.
// Backpressure is exercised by holding ready_i low while frames arrive and draining with random stalls.
module tb_uart_rx;
    localparam int CLK_HZ  = 100_000_000;
    localparam int BAUD_TB = 781_250;          // 16x divider of 8 -> 128 clocks per bit
    localparam int BIT     = 128;
    localparam int DEPTH   = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN  = 1'b1;
`else
    localparam bit PAR_EN  = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_pin;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_err_o;
    logic       overrun_o;
    logic       parity_err_o;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD_TB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_pin   (reset_pin),
        .rx          (rx),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err_o(parity_err_o)
`endif
    );
`ifndef UART_RX_PARITY_EN
    assign parity_err_o = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: bytes the receiver should be holding, and expected pulse counts.
    logic [7:0] model[$];
    int exp_fe = 0;
    int exp_ov = 0;
    int exp_pe = 0;

    // Pulse monitors count high cycles, so a stuck pulse shows as an excess.
    int fe_cnt = 0;
    int ov_cnt = 0;
    int pe_cnt = 0;
    int vld_cycles = 0;

    always @(negedge clk) begin
        if (reset_pin === 1'b1) begin
            if (frame_err_o)  fe_cnt++;
            if (overrun_o)    ov_cnt++;
            if (parity_err_o) pe_cnt++;
            if (valid_o)      vld_cycles++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame on the line; the model records what a correct receiver must do with it.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic bad_par,
                              input int bt, input bit lat_chk);
        drive_bit(1'b0, bt);
        for (int i = 0; i < 8; i++) drive_bit(b[i], bt);
        if (PAR_EN) drive_bit((^b) ^ bad_par, bt);
        if (lat_chk) begin
            // Byte must not appear before the mid-stop samples, and must appear shortly after.
            rx = stop;
            repeat (50) @(negedge clk);
            check("lat_early_valid", 32'(valid_o), 32'd0);
            repeat (50) @(negedge clk);
            check("lat_late_valid", 32'(valid_o), 32'd1);
            repeat (bt - 100) @(negedge clk);
        end else begin
            drive_bit(stop, bt);
        end
        if (!stop) exp_fe++;
        if (PAR_EN && bad_par) exp_pe++;
        if (stop && !(PAR_EN && bad_par)) begin
            if (model.size() < DEPTH) model.push_back(b);
            else exp_ov++;
        end
    endtask

    // Pop everything with random ready stalls, comparing each accepted byte in order.
    task automatic drain(input string tag);
        int budget;
        budget = 4000;
        while (model.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            ready_i = ($urandom_range(0, 3) != 0);
            if (valid_o && ready_i) begin
                check(tag, 32'(data_o), 32'(model.pop_front()));
            end
        end
        @(negedge clk);
        ready_i = 1'b0;
        check({tag, "_left"}, 32'(model.size()), 32'd0);
        @(negedge clk);
        check({tag, "_empty"}, 32'(valid_o), 32'd0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_frame_err"}, 32'(fe_cnt), 32'(exp_fe));
        check({tag, "_overrun"},   32'(ov_cnt), 32'(exp_ov));
        check({tag, "_parity_err"}, 32'(pe_cnt), 32'(exp_pe));
    endtask

    initial begin
        int k;
        int bt;
        logic [7:0] b;
        logic stop;
        logic badp;

        // Reset with the line idle.
        rx = 1'b1;
        ready_i = 1'b0;
        reset_pin = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_frame_err", 32'(frame_err_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        reset_pin = 1'b1;
        repeat (2000) @(negedge clk);
        check("idle_valid_cycles", 32'(vld_cycles), 32'd0);

        // 0xA5 with latency window, then a single-cycle pop.
        send_frame(8'hA5, 1'b1, 1'b0, BIT, 1'b1);
        check("a5_data", 32'(data_o), 32'h0000_00A5);
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        void'(model.pop_front());
        check("a5_popped_valid", 32'(valid_o), 32'd0);

        // Short low glitch: rejected by the start-bit vote.
        drive_bit(1'b0, 44);
        drive_bit(1'b1, 12 * BIT);
        check("glitch_valid", 32'(valid_o), 32'd0);
        check_counts("glitch");

        // 0x3C with stop held low for two bit times, then a good 0x11.
        send_frame(8'h3C, 1'b0, 1'b0, BIT, 1'b0);
        drive_bit(1'b0, BIT);
        drive_bit(1'b1, 2 * BIT);
        check("break_valid", 32'(valid_o), 32'd0);
        check_counts("break");
        send_frame(8'h11, 1'b1, 1'b0, BIT, 1'b0);
        drive_bit(1'b1, 8);
        drain("rx_11");

        // Five back-to-back bytes with no consumer: the fifth overruns.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0, BIT, 1'b0);
        drive_bit(1'b1, 8);
        check_counts("fill");
        drain("fill_drain");

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity bit 0 is wrong, 1 is right.
        send_frame(8'h07, 1'b1, 1'b1, BIT, 1'b0);
        drive_bit(1'b1, 8);
        check("par_bad_valid", 32'(valid_o), 32'd0);
        check_counts("par_bad");
        send_frame(8'h07, 1'b1, 1'b0, BIT, 1'b0);
        drive_bit(1'b1, 8);
        drain("par_good");
`endif

        // Randomized bursts with a small baud mismatch and occasional bad stop/parity.
        for (int r = 0; r < 3; r++) begin
            k  = $urandom_range(1, 6);
            bt = $urandom_range(126, 130);
            for (int j = 0; j < k; j++) begin
                b    = 8'($urandom);
                stop = ($urandom_range(0, 7) != 0);
                badp = ($urandom_range(0, 5) == 0);
                send_frame(b, stop, badp, bt, 1'b0);
                if (!stop) drive_bit(1'b1, 2 * bt);
            end
            drive_bit(1'b1, 2 * bt);
            drain("rnd_data");
            check_counts("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
